// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the highRISC core.
// Fetches 16-bit instructions over a req/valid handshake, decodes them into
// ALU controls, strobes register-file/flags writes and steps the PC
// (sequential, JMP, branch-if-zero). Instruction format:
//   [15:12] opcode, [11:9] Dest, [8:6] Src, [5:0] Imm.

package alu_sequencer_pkg;
  typedef enum logic [1:0] {
    NAND = 2'd0,
    NOR  = 2'd1,
    ADC  = 2'd2,
    LIU  = 2'd3
  } eOperation;
endpackage

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Run,
  input  logic [15:0]          InstrData,
  input  logic                 InstrValid,
  input  logic                 FlagZero,
  output logic                 InstrReq,
  output logic [AddrWidth-1:0] InstrAddr,
  output eOperation            Operation,
  output logic [5:0]           InImm,
  output logic [2:0]           SrcSel,
  output logic [2:0]           DestSel,
  output logic                 RegWrite,
  output logic                 FlagsWrite,
  output logic                 Busy,
  output logic                 Halted,
  output logic                 IllegalOp
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OPC_NAND = 4'h0,
    OPC_NOR  = 4'h1,
    OPC_ADC  = 4'h2,
    OPC_LIU  = 4'h3,
    OPC_JMP  = 4'h4,
    OPC_BZ   = 4'h5,
    OPC_HALT = 4'hF
  } opcode_e;

  state_e               r_state;
  state_e               w_next;
  logic [AddrWidth-1:0] r_pc;
  logic [15:0]          r_ir;
  eOperation            r_op;

  opcode_e              w_opcode;
  logic                 w_is_alu;
  logic                 w_is_halt;
  logic                 w_is_illegal;
  logic                 w_take;
  logic [AddrWidth-1:0] w_offset;
  logic                 w_fetch_done;

  assign w_opcode     = opcode_e'(r_ir[15:12]);
  assign w_offset     = AddrWidth'($signed(r_ir[5:0]));
  assign w_fetch_done = (r_state == S_FETCH) && InstrValid;

  // Decoded fields are taken straight from IR, which only changes on a
  // completed fetch, so they are stable from DECODE through WRITEBACK.
  assign InstrAddr = r_pc;
  assign Operation = r_op;
  assign InImm     = r_ir[5:0];
  assign SrcSel    = r_ir[8:6];
  assign DestSel   = r_ir[11:9];

  // Opcode classification of the instruction held in IR.
  always_comb begin
    w_is_alu     = 1'b0;
    w_is_halt    = 1'b0;
    w_is_illegal = 1'b0;
    w_take       = 1'b0;
    case (w_opcode)
      OPC_NAND, OPC_NOR, OPC_ADC, OPC_LIU: w_is_alu  = 1'b1;
      OPC_JMP:                             w_take    = 1'b1;
      OPC_BZ:                              w_take    = FlagZero;
      OPC_HALT:                            w_is_halt = 1'b1;
      default:                             w_is_illegal = 1'b1;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    w_next     = r_state;
    InstrReq   = 1'b0;
    RegWrite   = 1'b0;
    FlagsWrite = 1'b0;
    IllegalOp  = 1'b0;
    Busy       = 1'b1;
    Halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Run) w_next = S_FETCH;
      end
      S_FETCH: begin
        InstrReq = 1'b1;
        if (InstrValid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_illegal) begin
          IllegalOp = 1'b1;
          w_next    = S_HALTED;
        end else if (w_is_halt) begin
          w_next = S_HALTED;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_next = w_is_alu ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        RegWrite   = 1'b1;
        FlagsWrite = (w_opcode == OPC_ADC);
        w_next     = S_FETCH;
      end
      S_HALTED: begin
        Busy   = 1'b0;
        Halted = 1'b1;
        if (Run) w_next = S_FETCH;
      end
      default: begin
        Busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Instruction register, ALU operation register and program counter.
  // Operation is captured alongside IR at the fetch handshake so it is
  // already valid in DECODE; non-ALU opcodes present NAND to the ALU.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_pc <= '0;
      r_ir <= '0;
      r_op <= NAND;
    end else begin
      if (w_fetch_done) begin
        r_ir <= InstrData;
        r_pc <= r_pc + AddrWidth'(1);
        r_op <= (InstrData[15:14] == 2'b00) ? eOperation'(InstrData[13:12]) : NAND;
      end
      if ((r_state == S_EXECUTE) && w_take) begin
        r_pc <= r_pc + w_offset;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed vector table, hand-written corner
// sequences and random instruction streams checked against an
// instruction-level reference model.

module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        Clock;
  logic        nReset;
  logic        Run;
  logic [15:0] InstrData;
  logic        InstrValid;
  logic        FlagZero;
  logic        InstrReq;
  logic [7:0]  InstrAddr;
  eOperation   Operation;
  logic [5:0]  InImm;
  logic [2:0]  SrcSel;
  logic [2:0]  DestSel;
  logic        RegWrite;
  logic        FlagsWrite;
  logic        Busy;
  logic        Halted;
  logic        IllegalOp;

  alu_sequencer #(.AddrWidth(8)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Run        (Run),
    .InstrData  (InstrData),
    .InstrValid (InstrValid),
    .FlagZero   (FlagZero),
    .InstrReq   (InstrReq),
    .InstrAddr  (InstrAddr),
    .Operation  (Operation),
    .InImm      (InImm),
    .SrcSel     (SrcSel),
    .DestSel    (DestSel),
    .RegWrite   (RegWrite),
    .FlagsWrite (FlagsWrite),
    .Busy       (Busy),
    .Halted     (Halted),
    .IllegalOp  (IllegalOp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  int m_pc     = 0;

  typedef struct {
    int         cycles;
    bit         rw;
    bit         fw;
    bit         ill;
    bit         halt;
    logic [2:0] dest;
    logic [2:0] src;
    logic [5:0] imm;
    logic [1:0] op;
    int         next_pc;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    int          wt;
    bit          fz;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mke(int cyc, bit rw, bit fw, bit ill, bit halt,
                               logic [2:0] d, logic [2:0] s, logic [5:0] im,
                               logic [1:0] op, int npc);
    exp_t e;
    e.cycles = cyc; e.rw = rw; e.fw = fw; e.ill = ill; e.halt = halt;
    e.dest = d; e.src = s; e.imm = im; e.op = op; e.next_pc = npc;
    return e;
  endfunction

  function automatic vec_t mkv(logic [15:0] ins, int wt, bit fz, exp_t e);
    vec_t v;
    v.instr = ins; v.wt = wt; v.fz = fz; v.e = e;
    return v;
  endfunction

  // Instruction-level reference: what one instruction does to PC, how long
  // it takes with zero-wait memory after the fetch, and which writes it makes.
  function automatic exp_t model(logic [15:0] ins, int pc, bit fz);
    exp_t e;
    int   opc;
    int   off;
    int   np;
    opc = int'(ins[15:12]);
    off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
    e = mke(0, 0, 0, 0, 0, ins[11:9], ins[8:6], ins[5:0], ins[13:12], 0);
    np = pc + 1;
    if (opc <= 3) begin
      e.cycles = 4; e.rw = 1; e.fw = (opc == 2);
    end else if (opc == 4) begin
      e.cycles = 3; np = np + off;
    end else if (opc == 5) begin
      e.cycles = 3; if (fz) np = np + off;
    end else if (opc == 15) begin
      e.cycles = 2; e.halt = 1;
    end else begin
      e.cycles = 2; e.halt = 1; e.ill = 1;
    end
    e.next_pc = ((np % 256) + 256) % 256;
    return e;
  endfunction

  // Runs one instruction through the handshake (with wt wait cycles) and
  // compares its observed behaviour against e. Called at a negedge.
  task automatic exec_instr(input logic [15:0] ins, input int wt, input bit fz, input exp_t e);
    int         guard;
    int         cyc;
    int         rw;
    int         fw;
    int         ill;
    logic [2:0] d;
    logic [2:0] s;
    logic [5:0] im;
    logic [1:0] op;
    guard = 0;
    while (!InstrReq && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    check("fetch_req", 32'(InstrReq), 32'd1);
    check("fetch_addr", 32'(InstrAddr), 32'(m_pc));
    FlagZero = fz;
    for (int k = 0; k <= wt; k++) begin
      if (k > 0) begin
        @(negedge Clock);
        check("req_held", 32'(InstrReq), 32'd1);
      end
      InstrValid = (k == wt);
      InstrData  = (k == wt) ? ins : 16'($urandom);
      Run        = 1'($urandom);
    end
    cyc = 1; rw = 0; fw = 0; ill = 0;
    d = 'x; s = 'x; im = 'x; op = 'x;
    @(negedge Clock);
    while (Busy && !InstrReq && cyc < 12) begin
      cyc++;
      if (RegWrite) begin
        rw++;
        d = DestSel; s = SrcSel; im = InImm; op = Operation;
      end
      if (FlagsWrite) fw++;
      if (IllegalOp) ill++;
      InstrValid = 1'($urandom);
      InstrData  = 16'($urandom);
      Run        = 1'($urandom);
      @(negedge Clock);
    end
    InstrValid = 1'b0;
    Run        = 1'b0;
    check("cycles", 32'(cyc), 32'(e.cycles));
    check("regwrite_cnt", 32'(rw), 32'(e.rw));
    check("flagswrite_cnt", 32'(fw), 32'(e.fw));
    check("illegal_cnt", 32'(ill), 32'(e.ill));
    check("halted", 32'(Halted), 32'(e.halt));
    check("no_strobe_after", {29'd0, RegWrite, FlagsWrite, IllegalOp}, 32'd0);
    if (e.rw) begin
      check("dest_sel", 32'(d), 32'(e.dest));
      check("src_sel", 32'(s), 32'(e.src));
      check("in_imm", 32'(im), 32'(e.imm));
      check("operation", 32'(op), 32'(e.op));
    end
    m_pc = e.next_pc;
  endtask

  task automatic resume();
    check("halt_flag", 32'(Halted), 32'd1);
    check("halt_busy", 32'(Busy), 32'd0);
    Run = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge Clock);
      check("halt_hold", 32'(Halted), 32'd1);
    end
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    check("resume_req", 32'(InstrReq), 32'd1);
    check("resume_addr", 32'(InstrAddr), 32'(m_pc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    exp_t        e;
    logic [15:0] ins;
    logic [3:0]  opc;
    int          sel;
    int          wt;
    bit          fz;

    tbl[0]  = mkv(16'h2A85, 0, 0, mke(4, 1, 1, 0, 0, 3'd5, 3'd2, 6'h05, 2'd2, 1));
    tbl[1]  = mkv(16'h0000, 3, 0, mke(4, 1, 0, 0, 0, 3'd0, 3'd0, 6'h00, 2'd0, 2));
    tbl[2]  = mkv(16'h323F, 1, 1, mke(4, 1, 0, 0, 0, 3'd1, 3'd0, 6'h3F, 2'd3, 3));
    tbl[3]  = mkv(16'hF000, 0, 0, mke(2, 0, 0, 0, 1, 3'd0, 3'd0, 6'h00, 2'd0, 4));
    tbl[4]  = mkv(16'h5003, 0, 0, mke(3, 0, 0, 0, 0, 3'd0, 3'd0, 6'h03, 2'd0, 5));
    tbl[5]  = mkv(16'h403E, 2, 1, mke(3, 0, 0, 0, 0, 3'd0, 3'd0, 6'h3E, 2'd0, 4));
    tbl[6]  = mkv(16'h5003, 0, 1, mke(3, 0, 0, 0, 0, 3'd0, 3'd0, 6'h03, 2'd0, 8));
    tbl[7]  = mkv(16'h9000, 0, 0, mke(2, 0, 0, 1, 1, 3'd0, 3'd0, 6'h00, 2'd0, 9));
    tbl[8]  = mkv(16'h1E4A, 1, 0, mke(4, 1, 0, 0, 0, 3'd7, 3'd1, 6'h0A, 2'd1, 10));
    tbl[9]  = mkv(16'h4020, 0, 0, mke(3, 0, 0, 0, 0, 3'd0, 3'd0, 6'h20, 2'd0, 235));
    tbl[10] = mkv(16'h401F, 0, 0, mke(3, 0, 0, 0, 0, 3'd0, 3'd0, 6'h1F, 2'd0, 11));
    tbl[11] = mkv(16'h503C, 0, 1, mke(3, 0, 0, 0, 0, 3'd0, 3'd0, 6'h3C, 2'd0, 8));

    nReset = 1'b0; Run = 1'b0; InstrData = '0; InstrValid = 1'b0; FlagZero = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_req", 32'(InstrReq), 32'd0);
    check("rst_addr", 32'(InstrAddr), 32'd0);
    check("rst_op", 32'(Operation), 32'd0);
    check("rst_imm", 32'(InImm), 32'd0);
    check("rst_src", 32'(SrcSel), 32'd0);
    check("rst_dest", 32'(DestSel), 32'd0);
    check("rst_strobes", {29'd0, RegWrite, FlagsWrite, IllegalOp}, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);

    nReset = 1'b1;
    @(negedge Clock);
    check("idle_no_run", 32'(Busy), 32'd0);
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    m_pc = 0;

    // Directed program.
    for (int i = 0; i < 12; i++) begin
      exec_instr(tbl[i].instr, tbl[i].wt, tbl[i].fz, tbl[i].e);
      if (tbl[i].e.halt) resume();
    end

    // PC wrap: jump to 0xFF, execute NOR there, next fetch must be at 0x00.
    exec_instr(16'h4020, 0, 0, model(16'h4020, m_pc, 0));
    exec_instr(16'h4015, 0, 0, model(16'h4015, m_pc, 0));
    check("wrap_at_ff", 32'(InstrAddr), 32'hFF);
    exec_instr(16'h1000, 0, 0, model(16'h1000, m_pc, 0));
    check("wrap_to_00", 32'(InstrAddr), 32'h00);

    // Random instruction stream against the reference model.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: opc = 4'(sel);
        4, 6:       opc = 4'h4;
        5, 7:       opc = 4'h5;
        8:          opc = 4'hF;
        default:    opc = 4'($urandom_range(6, 14));
      endcase
      ins = {opc, 12'($urandom)};
      wt  = $urandom_range(0, 3);
      fz  = 1'($urandom);
      e   = model(ins, m_pc, fz);
      exec_instr(ins, wt, fz, e);
      if (e.halt) resume();
    end

    // Reset asserted for one edge during WRITEBACK.
    exec_instr(16'h2A85, 0, 0, model(16'h2A85, m_pc, 0));
    check("pre_rst_req", 32'(InstrReq), 32'd1);
    InstrValid = 1'b1; InstrData = 16'h2A85;
    @(negedge Clock);
    InstrValid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("wb_regwrite", 32'(RegWrite), 32'd1);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    check("rst_wb_regwrite", 32'(RegWrite), 32'd0);
    check("rst_wb_busy", 32'(Busy), 32'd0);
    check("rst_wb_addr", 32'(InstrAddr), 32'd0);
    check("rst_wb_req", 32'(InstrReq), 32'd0);
    @(negedge Clock);
    check("rst_wb_idle", 32'(Busy), 32'd0);
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    check("rst_restart_req", 32'(InstrReq), 32'd1);
    check("rst_restart_addr", 32'(InstrAddr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
